sht40_meas_ctrl: RTL and testbench

Sensor-side sequencer for the SHT40 humidity/temperature sensor, sitting directly upstream of the I2C master. It requests a measurement by presenting the address, command byte, write count and read count to the master, then consumes the six received bytes. It checks each 16-bit word against its CRC-8, aborts the master on a CRC mismatch, and publishes raw temperature and humidity words.

---
 rtl/sht40_meas_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sht40_meas_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sht40_meas_ctrl.sv
// SHT40 measurement sequencer in front of the I2C master: requests a measurement, captures six bytes, publishes temp/RH words.
// Build option: define SHT40_CRC_CHECK_EN to verify each word against its CRC-8 and abort the master on mismatch.
module sht40_meas_ctrl #(
  parameter logic [6:0] SENSOR_ADDR    = 7'h44,
  parameter logic [7:0] MEAS_CMD       = 8'hFD,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  master_state,
  input  logic [3:0]  bytes_received,
  input  logic [7:0]  data_received,
  output logic        processor_ready,
  output logic [6:0]  peripheral_address,
  output logic [7:0]  command_data_frames,
  output logic        i2c_writes,
  output logic [3:0]  sht_reads,
  output logic        crc_error_out,
  output logic        busy,
  output logic        valid,
  output logic [1:0]  err_code,
  output logic [15:0] temp_raw,
  output logic [15:0] rh_raw
);

  localparam int            TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, CHECK} state_t;

  state_t          state, state_nxt;
  logic [3:0]      prev_cnt;
  logic [2:0]      byte_idx;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      data_buf [4];
  logic            byte_new, to_hit, word_end, last_word, ms_idle, crc_ok, crc_fail;

  assign byte_new  = (bytes_received != prev_cnt);
  assign to_hit    = (to_cnt == TO_LAST);
  assign word_end  = (byte_idx == 3'd2) || (byte_idx == 3'd5);
  assign last_word = (byte_idx == 3'd6);
  assign ms_idle   = (master_state == 3'b000);
  assign crc_fail  = (state == CHECK) && !crc_ok;

  assign peripheral_address  = SENSOR_ADDR;
  assign command_data_frames = MEAS_CMD;
  assign i2c_writes          = 1'b1;
  assign sht_reads           = 4'd5;

`ifdef SHT40_CRC_CHECK_EN
  logic [7:0] crc_buf [2];

  // Bit-serial CRC-8, poly 0x31, init 0xFF, MSB first, no reflection or final XOR
  function automatic logic [7:0] crc8(input logic [15:0] word);
    logic [7:0] crc;
    logic       fb;
    crc = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      fb  = crc[7] ^ word[i];
      crc = {crc[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
    end
    return crc;
  endfunction

  assign crc_ok = last_word ? (crc8({data_buf[2], data_buf[3]}) == crc_buf[1])
                            : (crc8({data_buf[0], data_buf[1]}) == crc_buf[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_error_out <= 1'b0;
    else     crc_error_out <= crc_fail;
  end
`else
  assign crc_ok        = 1'b1;
  assign crc_error_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = REQ;
      REQ:   if (!ms_idle) state_nxt = XFER;
      XFER: begin
        // an arriving byte takes priority over end-of-transfer and timeout
        if (byte_new) begin
          if (word_end) state_nxt = CHECK;
        end else if (ms_idle || to_hit) begin
          state_nxt = IDLE;
        end
      end
      CHECK: state_nxt = (!crc_ok || last_word) ? IDLE : XFER;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    processor_ready = (state == REQ);
    busy            = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cnt <= 4'd0;
      byte_idx <= 3'd0;
      to_cnt   <= '0;
      err_code <= 2'b00;
      valid    <= 1'b0;
      temp_raw <= 16'd0;
      rh_raw   <= 16'd0;
    end else begin
      valid <= 1'b0;
      case (state)
        // master's byte count is never cleared, so capture its value as the baseline
        IDLE: if (start) begin
          err_code <= 2'b00;
          prev_cnt <= bytes_received;
        end
        REQ: if (!ms_idle) begin
          byte_idx <= 3'd0;
          to_cnt   <= '0;
        end
        XFER: begin
          if (byte_new) begin
            byte_idx <= byte_idx + 3'd1;
            prev_cnt <= bytes_received;
            to_cnt   <= '0;
          end else if (ms_idle) begin
            err_code <= 2'b11;
          end else if (to_hit) begin
            err_code <= 2'b10;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        CHECK: begin
          if (crc_fail) begin
            err_code <= 2'b01;
          end else if (last_word) begin
            valid    <= 1'b1;
            temp_raw <= {data_buf[0], data_buf[1]};
            rh_raw   <= {data_buf[2], data_buf[3]};
          end
        end
        default: ;
      endcase
    end
  end

  // Byte buffer carries no reset: a restarted transfer always overwrites it before use
  always_ff @(posedge clk) begin
    if (state == XFER && byte_new) begin
      case (byte_idx)
        3'd0: data_buf[0] <= data_received;
        3'd1: data_buf[1] <= data_received;
        3'd3: data_buf[2] <= data_received;
        3'd4: data_buf[3] <= data_received;
`ifdef SHT40_CRC_CHECK_EN
        3'd2: crc_buf[0]  <= data_received;
        3'd5: crc_buf[1]  <= data_received;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sht40_meas_ctrl.sv
// Directed bench for sht40_meas_ctrl: table of full measurements plus hand-written timeout, early-end and reset sequences.
module tb_sht40_meas_ctrl;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  master_state = 3'b000;
  logic [3:0]  bytes_received = 4'd0;
  logic [7:0]  data_received = 8'd0;
  logic        processor_ready, i2c_writes, crc_error_out, busy, valid;
  logic [6:0]  peripheral_address;
  logic [7:0]  command_data_frames;
  logic [3:0]  sht_reads;
  logic [1:0]  err_code;
  logic [15:0] temp_raw, rh_raw;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int crc_cnt = 0;

  sht40_meas_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .master_state(master_state),
    .bytes_received(bytes_received), .data_received(data_received),
    .processor_ready(processor_ready), .peripheral_address(peripheral_address),
    .command_data_frames(command_data_frames), .i2c_writes(i2c_writes),
    .sht_reads(sht_reads), .crc_error_out(crc_error_out), .busy(busy),
    .valid(valid), .err_code(err_code), .temp_raw(temp_raw), .rh_raw(rh_raw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cnt;
    logic [47:0] bytes;
    int          exp_valid;
    int          exp_crc;
    logic [15:0] exp_temp;
    logic [15:0] exp_rh;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (valid === 1'b1) valid_cnt++;
    if (crc_error_out === 1'b1) crc_cnt++;
  endtask

  task automatic begin_req(input logic [3:0] cnt);
    bytes_received = cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("req_ready", {31'd0, processor_ready}, 32'd1);
    chk("req_busy", {31'd0, busy}, 32'd1);
    master_state = 3'b010;
    step();
    chk("req_drop", {31'd0, processor_ready}, 32'd0);
    master_state = 3'b011;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bytes_received = bytes_received + 4'd1;
    data_received  = b;
    step();
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{4'd0,  48'hBEEF92666693, 1, 0, 16'hBEEF, 16'h6666, 2'b00};
`ifdef SHT40_CRC_CHECK_EN
    vecs[1] = '{4'd6,  48'h666600BEEF92, 0, 1, 16'hBEEF, 16'h6666, 2'b01};
`else
    vecs[1] = '{4'd6,  48'h666600BEEF92, 1, 0, 16'h6666, 16'hBEEF, 2'b00};
`endif
    vecs[2] = '{4'd14, 48'h666693BEEF92, 1, 0, 16'h6666, 16'hBEEF, 2'b00};
`ifdef SHT40_CRC_CHECK_EN
    vecs[3] = '{4'd3,  48'hBEEF92666600, 0, 1, 16'h6666, 16'hBEEF, 2'b01};
`else
    vecs[3] = '{4'd3,  48'hBEEF92666600, 1, 0, 16'hBEEF, 16'h6666, 2'b00};
`endif
    vecs[4] = '{4'd9,  48'hBEEF92666693, 1, 0, 16'hBEEF, 16'h6666, 2'b00};

    // reset state and constant outputs
    step();
    step();
    chk("rst_ready", {31'd0, processor_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_crc", {31'd0, crc_error_out}, 32'd0);
    chk("rst_err", {30'd0, err_code}, 32'd0);
    chk("rst_temp", {16'd0, temp_raw}, 32'd0);
    chk("rst_rh", {16'd0, rh_raw}, 32'd0);
    chk("const_addr", {25'd0, peripheral_address}, 32'h44);
    chk("const_cmd", {24'd0, command_data_frames}, 32'hFD);
    chk("const_wr", {31'd0, i2c_writes}, 32'd1);
    chk("const_rd", {28'd0, sht_reads}, 32'd5);
    rst = 1'b0;
    step();

    for (int v = 0; v < 5; v++) begin
      valid_cnt = 0;
      crc_cnt = 0;
      begin_req(vecs[v].cnt);
      for (int k = 0; k < 6; k++) send_byte(vecs[v].bytes[47 - 8*k -: 8]);
      master_state = 3'b110;
      step();
      master_state = 3'b000;
      step();
      chk($sformatf("v%0d_valid_pulses", v), valid_cnt, vecs[v].exp_valid);
      chk($sformatf("v%0d_crc_pulses", v), crc_cnt, vecs[v].exp_crc);
      chk($sformatf("v%0d_err", v), {30'd0, err_code}, {30'd0, vecs[v].exp_err});
      chk($sformatf("v%0d_temp", v), {16'd0, temp_raw}, {16'd0, vecs[v].exp_temp});
      chk($sformatf("v%0d_rh", v), {16'd0, rh_raw}, {16'd0, vecs[v].exp_rh});
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_ready", v), {31'd0, processor_ready}, 32'd0);
    end

    // timeout after two bytes
    begin
      int n;
      begin_req(4'd2);
      send_byte(8'hBE);
      send_byte(8'hEF);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
        step();
        n++;
      end
      chk("to_cycles", n, 38);
      chk("to_err", {30'd0, err_code}, 32'd2);
      chk("to_busy", {31'd0, busy}, 32'd0);
      chk("to_ready", {31'd0, processor_ready}, 32'd0);
      master_state = 3'b000;
      step();
    end

    // early end after four bytes, with an ignored start while busy
    begin_req(4'd5);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h92);
    send_byte(8'h66);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_ready", {31'd0, processor_ready}, 32'd0);
    chk("busy_start_busy", {31'd0, busy}, 32'd1);
    master_state = 3'b000;
    step();
    chk("early_err", {30'd0, err_code}, 32'd3);
    chk("early_busy", {31'd0, busy}, 32'd0);
    step();
    chk("early_no_req", {31'd0, processor_ready}, 32'd0);

    // asynchronous reset during byte 4, then a clean measurement with exact latency
    begin_req(4'd7);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h92);
    bytes_received = bytes_received + 4'd1;
    data_received = 8'h66;
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_err", {30'd0, err_code}, 32'd0);
    chk("arst_temp", {16'd0, temp_raw}, 32'd0);
    chk("arst_rh", {16'd0, rh_raw}, 32'd0);
    chk("arst_ready", {31'd0, processor_ready}, 32'd0);
    #2 rst = 1'b0;
    master_state = 3'b000;
    step();
    begin_req(4'd1);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h92);
    send_byte(8'h66);
    send_byte(8'h66);
    bytes_received = bytes_received + 4'd1;
    data_received = 8'h93;
    step();
    chk("lat_check_valid", {31'd0, valid}, 32'd0);
    chk("lat_check_busy", {31'd0, busy}, 32'd1);
    step();
    chk("lat_valid", {31'd0, valid}, 32'd1);
    chk("lat_busy", {31'd0, busy}, 32'd0);
    chk("lat_temp", {16'd0, temp_raw}, 32'hBEEF);
    chk("lat_rh", {16'd0, rh_raw}, 32'h6666);
    chk("lat_err", {30'd0, err_code}, 32'd0);
    step();
    chk("lat_valid_width", {31'd0, valid}, 32'd0);
    master_state = 3'b000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
